// File: rtl/ntt_dout_collector.sv
// Collects the interleaved NTT result stream into a natural-order buffer,
// reducing each coefficient into [0,q), then serves 1-cycle-latency reads.
module ntt_dout_collector #(
  parameter int DATA_W         = 32,
  parameter int RING_DEPTH_MAX = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         q,
  input  logic [3:0]                ring_depth,
  input  logic                      ntt_done,
  input  logic                      ntt_dout_valid,
  input  logic [DATA_W-1:0]         ntt_dout,
  input  logic                      rd_en,
  input  logic [RING_DEPTH_MAX-1:0] rd_addr,
  input  logic                      rd_clear,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_valid,
  output logic                      busy,
  output logic                      full,
  output logic                      cap_done,
  output logic                      err
);

  localparam int AW    = RING_DEPTH_MAX;
  localparam int DEPTH = 1 << AW;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_FULL    = 2'd3;

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [3:0]        depth_r;
  logic [3:0]        depth_sel_s;
  logic [AW-1:0]     beat_cnt_r;
  logic [AW:0]       n_s;
  logic [AW:0]       n_m1_s;
  logic [AW-1:0]     half_s;
  logic [AW-1:0]     wr_addr_s;
  logic [DATA_W-1:0] red_s;
  logic              restart_s;
  logic              take_s;
  logic              err_set_s;
  logic              err_clr_s;
  logic              rd_acc_s;
  logic              rd_oob_s;

  logic              wr_en_r;
  logic [AW-1:0]     wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] mem_q_r;
  logic              rd_zero_r;
  logic              rd_valid_r;
  logic              busy_r;
  logic              full_r;
  logic              cap_done_r;
  logic              err_r;

  // Clamp the requested ring depth into the supported range.
  always_comb begin
    depth_sel_s = ring_depth;
    if (ring_depth > 4'(RING_DEPTH_MAX)) begin
      depth_sel_s = 4'(RING_DEPTH_MAX);
    end else if (ring_depth == 4'd0) begin
      depth_sel_s = 4'd1;
    end else begin
      depth_sel_s = ring_depth;
    end
  end

  // Ring geometry, address de-interleave and single conditional subtract.
  always_comb begin
    n_s       = {{AW{1'b0}}, 1'b1} << depth_r;
    n_m1_s    = n_s - {{AW{1'b0}}, 1'b1};
    half_s    = n_s[AW:1];
    wr_addr_s = {1'b0, beat_cnt_r[AW-1:1]};
    if (beat_cnt_r[0]) begin
      wr_addr_s = {1'b0, beat_cnt_r[AW-1:1]} + half_s;
    end else begin
      wr_addr_s = {1'b0, beat_cnt_r[AW-1:1]};
    end
    if (ntt_dout >= q) begin
      red_s = ntt_dout - q;
    end else begin
      red_s = ntt_dout;
    end
    rd_oob_s = ({1'b0, rd_addr} >= n_s);
  end

  // Next-state and protocol-event decode.
  always_comb begin
    state_nxt_s = state_r;
    restart_s   = 1'b0;
    take_s      = 1'b0;
    err_set_s   = 1'b0;
    err_clr_s   = 1'b0;
    rd_acc_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ntt_done) begin
          state_nxt_s = ST_CAPTURE;
          restart_s   = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (ntt_done) begin
          state_nxt_s = ST_CAPTURE;
          restart_s   = 1'b1;
          err_set_s   = 1'b1;
        end else if (ntt_dout_valid) begin
          take_s = 1'b1;
          if (beat_cnt_r == n_m1_s[AW-1:0]) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            state_nxt_s = ST_CAPTURE;
          end
        end else begin
          state_nxt_s = ST_CAPTURE;
        end
      end
      ST_DRAIN: begin
        if (ntt_done) begin
          state_nxt_s = ST_CAPTURE;
          restart_s   = 1'b1;
          err_set_s   = 1'b1;
        end else begin
          state_nxt_s = ST_FULL;
          err_set_s   = ntt_dout_valid;
        end
      end
      ST_FULL: begin
        // A clear releases the buffer and swallows any same-cycle read.
        if (rd_clear) begin
          state_nxt_s = ST_IDLE;
          err_clr_s   = 1'b1;
        end else begin
          state_nxt_s = ST_FULL;
          rd_acc_s    = rd_en;
          err_set_s   = ntt_dout_valid;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Control state, write pipeline stage 1 and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      depth_r    <= 4'd1;
      beat_cnt_r <= {AW{1'b0}};
      err_r      <= 1'b0;
      busy_r     <= 1'b0;
      full_r     <= 1'b0;
      cap_done_r <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_zero_r  <= 1'b1;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= {AW{1'b0}};
      wr_data_r  <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (restart_s) begin
        depth_r    <= depth_sel_s;
        beat_cnt_r <= {AW{1'b0}};
      end else if (take_s) begin
        beat_cnt_r <= beat_cnt_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (err_clr_s) begin
        err_r <= 1'b0;
      end else if (err_set_s) begin
        err_r <= 1'b1;
      end
      busy_r     <= (state_nxt_s == ST_CAPTURE) || (state_nxt_s == ST_DRAIN);
      full_r     <= (state_nxt_s == ST_FULL);
      cap_done_r <= (state_r == ST_DRAIN) && (state_nxt_s == ST_FULL);
      rd_valid_r <= rd_acc_s;
      wr_en_r    <= take_s;
      if (take_s) begin
        wr_addr_r <= wr_addr_s;
        wr_data_r <= red_s;
      end
      if (rd_acc_s) begin
        rd_zero_r <= rd_oob_s;
      end
    end
  end

  // Coefficient buffer: writes only during capture, reads only in FULL.
  always_ff @(posedge clk) begin
    if (wr_en_r) begin
      mem_r[wr_addr_r] <= wr_data_r;
    end
    if (rd_acc_s) begin
      mem_q_r <= mem_r[rd_addr];
    end
  end

  assign rd_data  = rd_zero_r ? {DATA_W{1'b0}} : mem_q_r;
  assign rd_valid = rd_valid_r;
  assign busy     = busy_r;
  assign full     = full_r;
  assign cap_done = cap_done_r;
  assign err      = err_r;

endmodule
